// File: rtl/irq_ctrl.sv
// Four-channel interrupt controller: synchronized edge detection, maskable pending flags,
// fixed-priority one-hot pulses with hold-off. Define IRQ_TIMER_EN to drive channel 4 from an internal timer.
module irq_ctrl #(
    parameter int HOLDOFF      = 8,
    parameter int TIMER_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       req4,
    input  logic [3:0] mask,
    output logic       ie1,
    output logic       ie2,
    output logic       ie3,
    output logic       ie4,
    output logic [3:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        HOLD
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] ie_q;
    logic [3:0] s1, s2, s3;
    logic [3:0] edge_det;
    logic [3:0] set_vec;
    logic [3:0] ready;
    logic [3:0] grant;
    logic [3:0] issue;

    // Two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {req4, req3, req2, req1};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

`ifdef IRQ_TIMER_EN
    logic [15:0] tmr;
    logic        tick;

    assign tick = (tmr == 16'(TIMER_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if (tick) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 16'd1;
        end
    end

    // The timer tick bypasses the synchronizer; req4 is not used.
    assign set_vec = {tick, edge_det[2:0]};
`else
    assign set_vec = edge_det;
`endif

    assign ready = pending & mask;

    always_comb begin
        grant = '0;
        if (ready[0])      grant = 4'b0001;
        else if (ready[1]) grant = 4'b0010;
        else if (ready[2]) grant = 4'b0100;
        else if (ready[3]) grant = 4'b1000;
    end

    assign issue = (state == IDLE) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ie_q    <= '0;
            pending <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
        end else begin
            // A new edge on the issuing edge wins over the clear.
            pending <= (pending & ~issue) | set_vec;
            case (state)
                IDLE: begin
                    if (grant != '0) begin
                        ie_q  <= grant;
                        busy  <= 1'b1;
                        state <= FIRE;
                    end
                end
                FIRE: begin
                    ie_q <= '0;
                    if (HOLDOFF == 0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= 8'(HOLDOFF - 1);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    ie_q  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ie1 = ie_q[0];
    assign ie2 = ie_q[1];
    assign ie3 = ie_q[2];
    assign ie4 = ie_q[3];

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected ie pulses (channel, cycle) are queued when requests are
// driven and matched by a negedge monitor; status outputs are checked inline.
module tb_irq_ctrl;

`ifdef IRQ_TIMER_EN
    localparam int HO = 0;
    localparam int TP = 20;
`else
    localparam int HO = 8;
    localparam int TP = 1000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req1, req2, req3, req4;
    logic [3:0] mask;
    logic       ie1, ie2, ie3, ie4;
    logic [3:0] pending;
    logic       busy;
    logic [3:0] ie_vec;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] ch;
        int         at;
    } exp_t;

    exp_t sb[$];

    irq_ctrl #(.HOLDOFF(HO), .TIMER_PERIOD(TP)) dut (
        .clk(clk), .reset(reset),
        .req1(req1), .req2(req2), .req3(req3), .req4(req4),
        .mask(mask),
        .ie1(ie1), .ie2(ie2), .ie3(ie3), .ie4(ie4),
        .pending(pending), .busy(busy)
    );

    assign ie_vec = {ie4, ie3, ie2, ie1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] ch, input int at);
        exp_t e;
        e.ch = ch;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ie_vec != 4'h0) begin
            check("ie_onehot", 32'($onehot(ie_vec)), 32'd1);
            if (sb.size() == 0) begin
                check("ie_unexpected", 32'(ie_vec), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ie_chan", 32'(ie_vec), 32'(e.ch));
                check("ie_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        int base;
        int bc;
        reset = 1'b1;
        {req1, req2, req3, req4} = '0;
        mask = '0;
        step(3);
        check("rst_ie", 32'(ie_vec), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

`ifdef IRQ_TIMER_EN
        base = cyc;
        mask = 4'hF;
        for (int k = 0; k < 5; k++) push(4'b1000, base + 21 + 20 * k);
        repeat (105) begin
            step(1);
            req4 = 1'($urandom_range(0, 1));
        end
        check("timer_drained", 32'(sb.size()), 32'd0);
`else
        step(2);

        // single request latency
        mask = 4'hF;
        req2 = 1'b1;
        base = cyc;
        push(4'b0010, base + 4);
        step(2);
        check("lat_pend_e2", 32'(pending), 32'h0);
        step(1);
        check("lat_pend_e3", 32'(pending), 32'h2);
        check("lat_busy_e3", 32'(busy), 32'h0);
        req2 = 1'b0;
        step(1);
        check("lat_pend_clr", 32'(pending), 32'h0);
        check("lat_busy_fire", 32'(busy), 32'h1);
        bc = 1;
        repeat (12) begin
            step(1);
            if (busy) bc++;
        end
        check("busy_len", 32'(bc), 32'(1 + HO));

        // priority and spacing
        {req1, req3, req4} = 3'b111;
        base = cyc;
        push(4'b0001, base + 4);
        push(4'b0100, base + 4 + (HO + 2));
        push(4'b1000, base + 4 + 2 * (HO + 2));
        step(3);
        {req1, req3, req4} = 3'b000;
        step(32);
        check("prio_drained", 32'(sb.size()), 32'd0);

        // masking
        mask = 4'b1101;
        req2 = 1'b1;
        step(3);
        req2 = 1'b0;
        check("mask_pend", 32'(pending), 32'h2);
        step(5);
        check("mask_hold", 32'(pending), 32'h2);
        check("mask_idle", 32'(busy), 32'h0);
        mask = 4'hF;
        push(4'b0010, cyc + 1);
        step(1);
        check("unmask_clr", 32'(pending), 32'h0);
        step(12);

        // set/clear collision on channel 1
        mask = 4'b1110;
        req1 = 1'b1;
        base = cyc;
        step(2);
        req1 = 1'b0;
        step(2);
        req1 = 1'b1;
        step(2);
        check("coll_pre", 32'(pending), 32'h1);
        req1 = 1'b0;
        mask = 4'hF;
        push(4'b0001, base + 7);
        push(4'b0001, base + 7 + (HO + 2));
        step(1);
        check("coll_keep", 32'(pending), 32'h1);
        step(HO + 2);
        check("coll_clr", 32'(pending), 32'h0);
        step(12);

        // reset during HOLD with channel 3 pending
        req1 = 1'b1;
        base = cyc;
        push(4'b0001, base + 4);
        step(3);
        req1 = 1'b0;
        req3 = 1'b1;
        step(2);
        req3 = 1'b0;
        step(3);
        check("hold_pend", 32'(pending), 32'h4);
        check("hold_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("hrst_ie", 32'(ie_vec), 32'h0);
        check("hrst_pend", 32'(pending), 32'h0);
        check("hrst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(20);
        check("post_rst_pend", 32'(pending), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        // reset while a pulse is on the wire
        req2 = 1'b1;
        base = cyc;
        push(4'b0010, base + 4);
        step(3);
        req2 = 1'b0;
        step(1);
        #2 reset = 1'b1;
        #1;
        check("frst_ie", 32'(ie_vec), 32'h0);
        check("frst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(15);
        check("frst_pend", 32'(pending), 32'h0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
